pipe_stage_reg: RTL and testbench

- Parametrised, elastic successor of the fixed MEM/WB latch.
- One pipeline boundary with valid/ready handshake, flush (bubble insertion), optional 2-entry skid buffer, occupancy and stall-cycle statistics.
- Instantiated at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Payload is an opaque packed bundle; rd and RegWrite are additionally exposed for hazard/forwarding logic.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and MEM/WB bundle layout for the elastic pipeline-boundary register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_st_t;

  localparam int MEMWB_W      = 139;
  localparam int RD_LSB       = 0;
  localparam int REGW_BIT     = 5;
  localparam int MEMTOREG_BIT = 6;
  localparam int RESULT_LSB   = 7;
  localparam int READDATA_LSB = 71;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake, control and statistics bundle for one pipeline boundary.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 139,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occ;
  logic [RD_W-1:0]   fwd_rd;
  logic              fwd_we;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_clr;

  // master: upstream/downstream/control side; slave: the stage itself
  modport master (
    output in_valid, in_data, out_ready, flush, stall_clr,
    input  in_ready, out_valid, out_data, occ, fwd_rd, fwd_we, stall_cnt
  );
  modport slave (
    input  in_valid, in_data, out_ready, flush, stall_clr,
    output in_ready, out_valid, out_data, occ, fwd_rd, fwd_we, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline boundary: valid/ready stage with flush, optional 2-entry skid
// buffer, forwarding taps on the head beat and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W   = pipe_pkg::MEMWB_W,
  parameter int RD_W     = 5,
  parameter int REGW_BIT = 5,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);
  import pipe_pkg::*;

  logic              head_vld;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        occ_w;
  logic              in_rdy;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = bus.in_valid & in_rdy;
  assign out_fire = head_vld & bus.out_ready;

  generate
    if (SKID != 0) begin : g_skid
      stage_st_t         st_q;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] skid_q;
      logic [1:0]        occ_q;
      logic              rdy_q;

      // in_ready is a flop so out_ready never reaches upstream combinationally
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          st_q   <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
          occ_q  <= 2'd0;
          rdy_q  <= 1'b1;
        end else if (bus.flush) begin
          st_q  <= EMPTY;
          occ_q <= 2'd0;
          rdy_q <= 1'b1;
        end else begin
          case (st_q)
            EMPTY: begin
              if (in_fire) begin
                main_q <= bus.in_data;
                st_q   <= ONE;
                occ_q  <= 2'd1;
              end
            end
            ONE: begin
              if (in_fire && out_fire) begin
                main_q <= bus.in_data;
              end else if (in_fire) begin
                skid_q <= bus.in_data;
                st_q   <= FULL;
                occ_q  <= 2'd2;
                rdy_q  <= 1'b0;
              end else if (out_fire) begin
                st_q  <= EMPTY;
                occ_q <= 2'd0;
              end
            end
            FULL: begin
              if (out_fire) begin
                main_q <= skid_q;
                st_q   <= ONE;
                occ_q  <= 2'd1;
                rdy_q  <= 1'b1;
              end
            end
            default: begin
              st_q  <= EMPTY;
              occ_q <= 2'd0;
              rdy_q <= 1'b1;
            end
          endcase
        end
      end

      assign head_vld  = (st_q == ONE) || (st_q == FULL);
      assign head_data = main_q;
      assign occ_w     = occ_q;
      assign in_rdy    = rdy_q;
    end else begin : g_reg
      logic              vld_q;
      logic [DATA_W-1:0] data_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_q  <= 1'b0;
          data_q <= '0;
        end else if (bus.flush) begin
          vld_q <= 1'b0;
        end else if (in_fire) begin
          vld_q  <= 1'b1;
          data_q <= bus.in_data;
        end else if (out_fire) begin
          vld_q <= 1'b0;
        end
      end

      assign head_vld  = vld_q;
      assign head_data = data_q;
      assign occ_w     = {1'b0, vld_q};
      assign in_rdy    = ~vld_q | bus.out_ready;
    end
  endgenerate

  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.stall_clr)
      stall_d = '0;
    else if (head_vld && !bus.out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = head_vld;
  assign bus.out_data  = head_data;
  assign bus.occ       = occ_w;
  assign bus.fwd_rd    = head_vld ? head_data[RD_W-1:0] : '0;
  assign bus.fwd_we    = head_vld & head_data[REGW_BIT];
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid-buffered stage (CNT_W=16) and a single-register stage (CNT_W=3).
module tb_pipe_stage_reg;
  localparam int W = 139;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(W), .RD_W(5), .CNT_W(16)) bus ();
  pipe_stage_reg_if #(.DATA_W(W), .RD_W(5), .CNT_W(3))  sbus ();

  pipe_stage_reg #(.DATA_W(W), .RD_W(5), .REGW_BIT(5), .SKID(1), .CNT_W(16))
    u_dut (.clk(clk), .reset(reset), .bus(bus));
  pipe_stage_reg #(.DATA_W(W), .RD_W(5), .REGW_BIT(5), .SKID(0), .CNT_W(3))
    u_sat (.clk(clk), .reset(reset), .bus(sbus));

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_s[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    exp_q.push_back(d);
  endtask

  // monitors: every beat leaving a stage must be the oldest expected one
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut_beat: got %0h expected none", bus.out_data);
      end else chk("dut_beat", bus.out_data, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset && sbus.out_valid && sbus.out_ready) begin
      if (exp_s.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sat_beat: got %0h expected none", sbus.out_data);
      end else chk("sat_beat", sbus.out_data, exp_s.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0; bus.flush = 0; bus.stall_clr = 0;
    sbus.in_valid = 0; sbus.in_data = '0; sbus.out_ready = 0; sbus.flush = 0; sbus.stall_clr = 0;

    // reset / idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_occ", bus.occ, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_stall", bus.stall_cnt, 0);
    chk("rst_fwd_we", bus.fwd_we, 0);

    // streaming
    bus.out_ready = 1;
    send(139'h11);
    step(); chk("str_valid", bus.out_valid, 1); chk("str_occ1", bus.occ, 1);
    send(139'h22);
    step(); chk("str_occ2", bus.occ, 1);
    send(139'h33);
    step(); bus.in_valid = 0;
    step(); chk("str_occ_end", bus.occ, 0); chk("str_stall", bus.stall_cnt, 0);

    // backpressure through the skid entry
    bus.out_ready = 0;
    send(139'hA);
    step(); chk("bp_rdy1", bus.in_ready, 1); chk("bp_occ1", bus.occ, 1);
    send(139'hB);
    step(); chk("bp_rdy2", bus.in_ready, 0); chk("bp_occ2", bus.occ, 2);
    send(139'hC);
    step(); chk("bp_rdy3", bus.in_ready, 0); chk("bp_occ3", bus.occ, 2);
    chk("bp_stall", bus.stall_cnt, 2);
    bus.out_ready = 1;
    step(); chk("bp_rdy4", bus.in_ready, 1);
    step(); bus.in_valid = 0;
    step(); chk("bp_occ_end", bus.occ, 0); chk("bp_stall_end", bus.stall_cnt, 2);

    // flush while full, with a beat offered in the flush cycle
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 139'hA;
    step(); bus.in_data = 139'hB;
    step(); chk("fl_occ_full", bus.occ, 2);
    bus.in_data = 139'hD; bus.flush = 1;
    step(); bus.flush = 0; bus.in_valid = 0;
    chk("fl_valid", bus.out_valid, 0); chk("fl_occ", bus.occ, 0);
    chk("fl_rdy", bus.in_ready, 1); chk("fl_stall_kept", bus.stall_cnt, 4);
    bus.out_ready = 1;
    send(139'hE);
    step(); bus.in_valid = 0; bus.out_ready = 0;
    chk("fl_e_valid", bus.out_valid, 1);
    step(); chk("clr_pre", bus.stall_cnt, 5);
    bus.stall_clr = 1;
    step(); chk("clr_wins", bus.stall_cnt, 0);
    bus.stall_clr = 0; bus.out_ready = 1;
    step(); chk("fl_e_gone", bus.out_valid, 0);

    // forwarding taps
    bus.out_ready = 0;
    p = '0; p[100] = 1'b1; p[4:0] = 5'd7; p[5] = 1'b1;
    send(p);
    step(); bus.in_valid = 0;
    chk("fwd_rd", bus.fwd_rd, 7); chk("fwd_we", bus.fwd_we, 1);
    bus.out_ready = 1;
    step(); chk("fwd_rd_empty", bus.fwd_rd, 0); chk("fwd_we_empty", bus.fwd_we, 0);
    p = '0; p[4:0] = 5'd9;
    send(p);
    step(); bus.in_valid = 0;
    chk("fwd_rd_norw", bus.fwd_rd, 9); chk("fwd_we_norw", bus.fwd_we, 0);
    step();

    // single-register stage: comb ready and counter saturation
    chk("sat_rdy_empty", sbus.in_ready, 1);
    sbus.in_valid = 1; sbus.in_data = 139'h55; exp_s.push_back(139'h55);
    step(); sbus.in_valid = 0;
    chk("sat_occ", sbus.occ, 1); chk("sat_rdy_full", sbus.in_ready, 0);
    repeat (10) step();
    chk("sat_stall", sbus.stall_cnt, 7);
    sbus.out_ready = 1;
    #1 chk("sat_rdy_comb", sbus.in_ready, 1);
    sbus.in_valid = 1; sbus.in_data = 139'h66; exp_s.push_back(139'h66);
    step(); sbus.in_valid = 0;
    step(); chk("sat_occ_end", sbus.occ, 0);

    // asynchronous reset mid-cycle with a beat held
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 139'h77;
    step(); bus.in_valid = 0;
    chk("ar_pre_valid", bus.out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", bus.out_valid, 0); chk("ar_occ", bus.occ, 0);
    chk("ar_data", bus.out_data, 0); chk("ar_fwd_we", bus.fwd_we, 0);
    chk("ar_rdy", bus.in_ready, 1); chk("ar_sat_stall", sbus.stall_cnt, 0);
    chk("ar_sat_occ", sbus.occ, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    chk("ar_post_valid", bus.out_valid, 0);

    chk("sb_dut_drained", exp_q.size(), 0);
    chk("sb_sat_drained", exp_s.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
